data_memory: RTL and testbench

Byte-addressable, little-endian data memory for the pipelined RV32 core's MEM stage. Performs byte, halfword and word stores on the rising clock edge. Provides combinational loads with sign or zero extension, covering the LB/LH/LW/LBU/LHU and SB/SH/SW access forms.

---
 rtl/data_memory.sv | 93 +++++++++
 tb/tb_data_memory.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// Byte-addressable little-endian data memory with sub-word stores and sign/zero-extended loads.
// Build option DATA_MEMORY_RESET_CLEAR_EN: reset asynchronously clears the array and forces o_rd to 0.
module data_memory #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wd,
  input  logic [1:0]  i_mask_type,
  input  logic        i_ext_type,
  output logic [31:0] o_rd
);

  localparam logic [1:0] MaskByte = 2'b00;
  localparam logic [1:0] MaskHalf = 2'b01;
  localparam logic [1:0] MaskWord = 2'b10;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] word_idx;
  logic [3:0]    byte_en;
  logic [31:0]   wr_data;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   load_data;

  assign word_idx = i_addr[AW+1:2];

  // Store data is replicated across lanes so each enabled lane picks up its own slice.
  always_comb begin
    byte_en = 4'b0000;
    wr_data = i_wd;
    case (i_mask_type)
      MaskByte: begin
        byte_en = 4'b0001 << i_addr[1:0];
        wr_data = {4{i_wd[7:0]}};
      end
      MaskHalf: begin
        byte_en = i_addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{i_wd[15:0]}};
      end
      MaskWord: byte_en = 4'b1111;
      default:  byte_en = 4'b0000;
    endcase
  end

`ifdef DATA_MEMORY_RESET_CLEAR_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int w = 0; w < int'(DEPTH_WORDS); w++) begin
        mem[w] <= '0;
      end
    end else if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end
`else
  // No reset on the array so it maps onto RAM with byte-write enables; reset only gates writes.
  always_ff @(posedge i_clk) begin
    if (i_we && !i_rst) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end
`endif

  assign rd_word = mem[word_idx];
  assign rd_byte = rd_word[{i_addr[1:0], 3'b000} +: 8];
  assign rd_half = i_addr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_data = 32'h0000_0000;
    case (i_mask_type)
      MaskByte: load_data = {{24{rd_byte[7] & ~i_ext_type}}, rd_byte};
      MaskHalf: load_data = {{16{rd_half[15] & ~i_ext_type}}, rd_half};
      MaskWord: load_data = rd_word;
      default:  load_data = 32'h0000_0000;
    endcase
  end

`ifdef DATA_MEMORY_RESET_CLEAR_EN
  assign o_rd = i_rst ? 32'h0000_0000 : load_data;
`else
  assign o_rd = load_data;
`endif

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed scenarios plus randomized ops against a byte-array model.
module tb_data_memory;

  localparam int unsigned DW    = 64;
  localparam int unsigned NBYTE = DW * 4;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_we;
  logic [31:0] i_addr;
  logic [31:0] i_wd;
  logic [1:0]  i_mask_type;
  logic        i_ext_type;
  logic [31:0] o_rd;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [7:0] ref_mem [NBYTE];

  data_memory #(.DEPTH_WORDS(DW)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_we        (i_we),
    .i_addr      (i_addr),
    .i_wd        (i_wd),
    .i_mask_type (i_mask_type),
    .i_ext_type  (i_ext_type),
    .o_rd        (o_rd)
  );

  always #5 i_clk = ~i_clk;

  function automatic int unsigned wrap(input logic [31:0] a);
    return int'(a % NBYTE);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] m,
                                             input logic e);
    int unsigned base;
    logic [7:0]  b;
    logic [15:0] h;
    base = wrap(a);
    case (m)
      2'b00: begin
        b = ref_mem[base];
        return e ? {24'h0, b} : {{24{b[7]}}, b};
      end
      2'b01: begin
        base = base - (base % 2);
        h = {ref_mem[base + 1], ref_mem[base]};
        return e ? {16'h0, h} : {{16{h[15]}}, h};
      end
      2'b10: begin
        base = base - (base % 4);
        return {ref_mem[base + 3], ref_mem[base + 2], ref_mem[base + 1], ref_mem[base]};
      end
      default: return 32'h0;
    endcase
  endfunction

  function automatic void model_store(input logic [31:0] a, input logic [31:0] d,
                                      input logic [1:0] m);
    int unsigned base;
    base = wrap(a);
    case (m)
      2'b00: ref_mem[base] = d[7:0];
      2'b01: begin
        base = base - (base % 2);
        ref_mem[base]     = d[7:0];
        ref_mem[base + 1] = d[15:8];
      end
      2'b10: begin
        base = base - (base % 4);
        for (int k = 0; k < 4; k++) ref_mem[base + k] = d[8*k +: 8];
      end
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] expected_rd();
`ifdef DATA_MEMORY_RESET_CLEAR_EN
    if (i_rst) return 32'h0;
`endif
    return model_load(i_addr, i_mask_type, i_ext_type);
  endfunction

  task automatic model_reset();
`ifdef DATA_MEMORY_RESET_CLEAR_EN
    for (int k = 0; k < int'(NBYTE); k++) ref_mem[k] = 8'h00;
`endif
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set(input logic we, input logic [31:0] a, input logic [31:0] d,
                     input logic [1:0] m, input logic e);
    i_we = we; i_addr = a; i_wd = d; i_mask_type = m; i_ext_type = e;
    #1;
  endtask

  task automatic tick();
    @(posedge i_clk);
    if (i_we && !i_rst) model_store(i_addr, i_wd, i_mask_type);
    #1;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [1:0] m, input logic e,
                    input logic [31:0] exp);
    set(1'b0, a, 32'h0, m, e);
    check(tag, o_rd, exp);
  endtask

  initial begin
    for (int k = 0; k < int'(NBYTE); k++) ref_mem[k] = 8'hxx;
    i_rst = 1'b1;
    model_reset();
    set(1'b0, 32'd1000, 32'h0, 2'b10, 1'b0);
    #12;
    i_rst = 1'b0;
    tick();

    // Clear the target word so results hold with or without reset clearing.
    set(1'b1, 32'd1000, 32'h0, 2'b10, 1'b0); tick();

    set(1'b1, 32'd1000, 32'h1234_5678, 2'b00, 1'b0); tick();
    rd("sb_byte_rd", 32'd1000, 2'b00, 1'b0, 32'h0000_0078);
    rd("sb_word_rd", 32'd1000, 2'b10, 1'b0, 32'h0000_0078);

    set(1'b1, 32'd1000, 32'h1234_5678, 2'b01, 1'b0); tick();
    rd("sh_half_rd", 32'd1000, 2'b01, 1'b0, 32'h0000_5678);
    set(1'b1, 32'd1000, 32'h1234_5678, 2'b10, 1'b0); tick();
    rd("sw_word_rd", 32'd1000, 2'b10, 1'b0, 32'h1234_5678);

    set(1'b1, 32'd1000, 32'hFFFF_FFFF, 2'b11, 1'b0); tick();
    rd("rsv_store_word", 32'd1000, 2'b10, 1'b0, 32'h1234_5678);
    rd("rsv_load_zero", 32'd1000, 2'b11, 1'b0, 32'h0000_0000);

    set(1'b1, 32'd1001, 32'h0000_00AA, 2'b00, 1'b0); tick();
    rd("sb1001_word", 32'd1000, 2'b10, 1'b0, 32'h1234_AA78);
    rd("lb1001_signed", 32'd1001, 2'b00, 1'b0, 32'hFFFF_FFAA);

    // Before the edge the old word is still visible.
    set(1'b1, 32'd1000, 32'h0CBA_92B4, 2'b10, 1'b0);
    check("pre_edge_old", o_rd, 32'h1234_AA78);
    tick();
    check("post_edge_new", o_rd, 32'h0CBA_92B4);
    rd("lb_signed",   32'd1000, 2'b00, 1'b0, 32'hFFFF_FFB4);
    rd("lbu",         32'd1000, 2'b00, 1'b1, 32'h0000_00B4);
    rd("lh_signed",   32'd1000, 2'b01, 1'b0, 32'hFFFF_92B4);
    rd("lhu",         32'd1000, 2'b01, 1'b1, 32'h0000_92B4);
    rd("lh1002",      32'd1002, 2'b01, 1'b0, 32'h0000_0CBA);
    rd("lh1001_align", 32'd1001, 2'b01, 1'b1, 32'h0000_92B4);
    rd("lw_ext_ign",  32'd1003, 2'b10, 1'b1, 32'h0CBA_92B4);

    // Upper address bits are ignored.
    set(1'b1, 32'hABCD_0008, 32'hCAFE_F00D, 2'b10, 1'b0); tick();
    rd("wrap_word", 32'h0000_0008 + NBYTE, 2'b10, 1'b0, 32'hCAFE_F00D);

    // Asynchronous reset between edges, then a write attempted under reset.
    set(1'b0, 32'd1000, 32'h0, 2'b10, 1'b0);
    #3;
    i_rst = 1'b1;
    model_reset();
    #1;
    check("rst_async_rd", o_rd, expected_rd());
    set(1'b1, 32'd1000, 32'hDEAD_BEEF, 2'b10, 1'b0);
    tick();
    #3;
    i_rst = 1'b0;
    rd("rst_blocked_wr", 32'd1000, 2'b10, 1'b0, expected_rd());
    tick();

    // Fill the whole array, then random traffic against the model.
    for (int w = 0; w < int'(DW); w++) begin
      set(1'b1, 32'(w * 4), $urandom, 2'b10, 1'b0);
      tick();
    end
    for (int n = 0; n < 400; n++) begin
      set(1'($urandom_range(0, 1)), $urandom, $urandom, 2'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)));
      check("rand_rd", o_rd, expected_rd());
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
